// File: rtl/camera_strip_writer.sv
// camera_strip_writer
//
// Packs the incoming camera pixel stream into NP-pixel words and writes them
// into a two-bank (ping-pong) line-buffer RAM. Each bank holds one strip of
// STRIP_H lines. When a strip is complete it is announced to the downstream
// strip reader. The pixel source is stalled while the next write bank is
// still owned by the reader.
//
// Ports:
//   clk, resetn         - single clock, asynchronous active-low reset
//   in_valid/in_ready   - pixel handshake (in_ready is registered)
//   in_pixel            - pixel data, PS bits
//   in_frame_start      - marks the first pixel of a frame
//   in_line_end         - marks the last pixel of a line
//   wd/wa/we/wbe        - registered RAM write port (data, word address,
//                         strobe, per-pixel byte enables)
//   strip_valid         - one-cycle pulse, a strip is complete in RAM
//   strip_bank          - bank of the completed strip
//   strip_release       - one-cycle pulse, the oldest busy bank is free
//   err_long_line       - sticky: a line exceeded LINE_W pixels
//   err_partial_strip   - sticky: a frame started in the middle of a strip
//
// Configuration macro: STRIP_WRITER_ERR_EN
//   defined     - the two error flags are sticky, cleared only by resetn
//   not defined - both error outputs are tied to 0

module camera_strip_writer #(
  parameter int PS      = 8,
  parameter int NP      = 8,
  parameter int DW      = NP * PS,
  parameter int LINE_W  = 720,
  parameter int STRIP_H = 16,
  localparam int WPL        = (LINE_W + NP - 1) / NP,
  localparam int BANK_WORDS = WPL * STRIP_H,
  localparam int DEPTH      = 2 * BANK_WORDS,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  input  logic [PS-1:0] in_pixel,
  input  logic          in_frame_start,
  input  logic          in_line_end,
  output logic          in_ready,
  output logic [DW-1:0] wd,
  output logic [AW-1:0] wa,
  output logic          we,
  output logic [NP-1:0] wbe,
  output logic          strip_valid,
  output logic          strip_bank,
  input  logic          strip_release,
  output logic          err_long_line,
  output logic          err_partial_strip
);

  localparam int LW = (STRIP_H > 1) ? $clog2(STRIP_H) : 1;
  localparam int WW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int SW = (NP > 1) ? $clog2(NP) : 1;

  // Word/slot position of the last pixel that fits inside LINE_W.
  localparam int LAST_WORD = (LINE_W - 1) / NP;
  localparam int LAST_SLOT = (LINE_W - 1) % NP;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    RUN,
    STALL
  } state_e;

  state_e        state_q;
  logic          ready_q;
  logic          wb_q;
  logic [1:0]    busy_q;
  logic [LW-1:0] line_q;
  logic [WW-1:0] word_q;
  logic [SW-1:0] slot_q;
  logic          ovf_q;
  logic [DW-1:0] pack_q;
  logic [NP-1:0] be_q;
  logic          we_q;
  logic [AW-1:0] wa_q;
  logic [DW-1:0] wd_q;
  logic [NP-1:0] wbe_q;
  logic          done_q;
  logic          done_bank_q;
  logic          strip_valid_q;
  logic          strip_bank_q;

  logic          take;
  logic          restart;
  logic [LW-1:0] cur_line;
  logic [WW-1:0] cur_word;
  logic [SW-1:0] cur_slot;
  logic          cur_ovf;
  logic          drop;
  logic          last_idx;
  logic          do_write;
  logic          line_wrap;
  logic          oldest;
  logic [DW-1:0] pack_d;
  logic [NP-1:0] be_d;
  logic [AW-1:0] wa_d;
  logic [1:0]    busy_d;
  logic          wb_d;
  logic          stall_d;

  // A frame-start pixel restarts the counters, so the current pixel is
  // evaluated against "effective" counters that are already zeroed; any
  // half-packed word is thrown away. Once a line has reached LINE_W pixels
  // (ovf), further pixels up to in_line_end are accepted but not stored.
  // Busy banks always complete alternately, so when both are busy the oldest
  // is the current write bank; otherwise it is the single busy one.
  always_comb begin
    take      = in_valid & ready_q &
                ((state_q == RUN) | ((state_q == WAIT_FRAME) & in_frame_start));
    restart   = take & in_frame_start;
    cur_line  = restart ? '0 : line_q;
    cur_word  = restart ? '0 : word_q;
    cur_slot  = restart ? '0 : slot_q;
    cur_ovf   = restart ? 1'b0 : ovf_q;
    drop      = cur_ovf;
    last_idx  = (cur_word == WW'(LAST_WORD)) & (cur_slot == SW'(LAST_SLOT));

    pack_d = restart ? '0 : pack_q;
    be_d   = restart ? '0 : be_q;
    if (!drop) begin
      pack_d[int'(cur_slot)*PS +: PS] = in_pixel;
      be_d[cur_slot]                  = 1'b1;
    end

    do_write  = take & ~drop &
                ((cur_slot == SW'(NP - 1)) | in_line_end | last_idx);
    wa_d      = AW'(int'(wb_q) * BANK_WORDS + int'(cur_line) * WPL + int'(cur_word));
    line_wrap = take & in_line_end & (cur_line == LW'(STRIP_H - 1));

    oldest = (busy_q == 2'b11) ? wb_q : busy_q[1];
    busy_d = busy_q;
    if (strip_release && (busy_q != 2'b00)) begin
      busy_d[oldest] = 1'b0;
    end
    if (line_wrap) begin
      busy_d[wb_q] = 1'b1;
    end
    wb_d    = line_wrap ? ~wb_q : wb_q;
    stall_d = line_wrap & busy_d[wb_d];
  end

  // Main sequencer: FSM, counters, packing register and the registered RAM
  // write port. strip_valid is delayed one extra cycle behind the final write
  // so the reader only sees a strip once its last word is in RAM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= WAIT_FRAME;
      ready_q       <= 1'b1;
      wb_q          <= 1'b0;
      busy_q        <= 2'b00;
      line_q        <= '0;
      word_q        <= '0;
      slot_q        <= '0;
      ovf_q         <= 1'b0;
      pack_q        <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      wa_q          <= '0;
      wd_q          <= '0;
      wbe_q         <= '0;
      done_q        <= 1'b0;
      done_bank_q   <= 1'b0;
      strip_valid_q <= 1'b0;
      strip_bank_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wb_q   <= wb_d;

      we_q <= do_write;
      if (do_write) begin
        wa_q  <= wa_d;
        wd_q  <= pack_d;
        wbe_q <= be_d;
      end

      done_q <= line_wrap;
      if (line_wrap) begin
        done_bank_q <= wb_q;
      end
      strip_valid_q <= done_q;
      if (done_q) begin
        strip_bank_q <= done_bank_q;
      end

      if (take) begin
        if (in_line_end) begin
          line_q <= line_wrap ? '0 : cur_line + LW'(1);
          word_q <= '0;
          slot_q <= '0;
          ovf_q  <= 1'b0;
          pack_q <= '0;
          be_q   <= '0;
        end else if (do_write) begin
          line_q <= cur_line;
          word_q <= last_idx ? cur_word : cur_word + WW'(1);
          slot_q <= '0;
          ovf_q  <= last_idx;
          pack_q <= '0;
          be_q   <= '0;
        end else if (!drop) begin
          line_q <= cur_line;
          word_q <= cur_word;
          slot_q <= cur_slot + SW'(1);
          ovf_q  <= 1'b0;
          pack_q <= pack_d;
          be_q   <= be_d;
        end
      end

      case (state_q)
        WAIT_FRAME: begin
          if (take) begin
            state_q <= stall_d ? STALL : RUN;
            ready_q <= ~stall_d;
          end
        end
        RUN: begin
          if (stall_d) begin
            state_q <= STALL;
            ready_q <= 1'b0;
          end
        end
        STALL: begin
          if (!busy_d[wb_q]) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_FRAME;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef STRIP_WRITER_ERR_EN
  logic err_long_q;
  logic err_partial_q;
  logic mid_strip;

  // A frame start only counts as abandoning a strip if some pixel of the
  // current strip has already been consumed.
  always_comb begin
    mid_strip = restart & (state_q == RUN) &
                ((line_q != '0) | (word_q != '0) | (slot_q != '0));
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_long_q    <= 1'b0;
      err_partial_q <= 1'b0;
    end else begin
      if (take && drop) begin
        err_long_q <= 1'b1;
      end
      if (mid_strip) begin
        err_partial_q <= 1'b1;
      end
    end
  end

  assign err_long_line     = err_long_q;
  assign err_partial_strip = err_partial_q;
`else
  assign err_long_line     = 1'b0;
  assign err_partial_strip = 1'b0;
`endif

  assign in_ready    = ready_q;
  assign we          = we_q;
  assign wa          = wa_q;
  assign wd          = wd_q;
  assign wbe         = wbe_q;
  assign strip_valid = strip_valid_q;
  assign strip_bank  = strip_bank_q;

endmodule

// File: tb/tb_camera_strip_writer.sv
// Testbench for camera_strip_writer.
// Directed stimulus drives lines of pixels; for every word the DUT should
// write, the expected address/data/enables are queued before the pixel is
// sent. A separate monitor pops and compares on every RAM write and every
// strip_valid pulse, and also checks strip_valid follows the final write by
// exactly one cycle.

`timescale 1ns/1ps

module tb_camera_strip_writer;

  localparam int PS         = 8;
  localparam int NP         = 8;
  localparam int LINE_W     = 720;
  localparam int STRIP_H    = 16;
  localparam int WPL        = 90;
  localparam int BANK_WORDS = 1440;
  localparam int AW         = 12;

`ifdef STRIP_WRITER_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [63:0]   wd;
    logic [7:0]    wbe;
  } wr_t;

  logic          clk;
  logic          resetn;
  logic          in_valid;
  logic [PS-1:0] in_pixel;
  logic          in_frame_start;
  logic          in_line_end;
  logic          in_ready;
  logic [63:0]   wd;
  logic [AW-1:0] wa;
  logic          we;
  logic [7:0]    wbe;
  logic          strip_valid;
  logic          strip_bank;
  logic          strip_release;
  logic          err_long_line;
  logic          err_partial_strip;

  wr_t  expWrQ[$];
  logic expStripQ[$];
  int   checkCount;
  int   passCount;
  int   cycle;
  int   lastWriteCycle;

  camera_strip_writer dut (
    .clk              (clk),
    .resetn           (resetn),
    .in_valid         (in_valid),
    .in_pixel         (in_pixel),
    .in_frame_start   (in_frame_start),
    .in_line_end      (in_line_end),
    .in_ready         (in_ready),
    .wd               (wd),
    .wa               (wa),
    .we               (we),
    .wbe              (wbe),
    .strip_valid      (strip_valid),
    .strip_bank       (strip_bank),
    .strip_release    (strip_release),
    .err_long_line    (err_long_line),
    .err_partial_strip(err_partial_strip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to measure strip_valid latency.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT write and strip announcement against the
  // scoreboard queues.
  always @(negedge clk) begin
    if (resetn) begin
      if (strip_valid) begin
        if (expStripQ.size() == 0) begin
          checkOutput("unexpected_strip_valid", 64'(strip_valid), 64'd0);
        end else begin
          checkOutput("strip_bank", 64'(strip_bank), 64'(expStripQ.pop_front()));
          checkOutput("strip_valid_latency", 64'(cycle - lastWriteCycle), 64'd1);
        end
      end
      if (we) begin
        lastWriteCycle = cycle;
        if (expWrQ.size() == 0) begin
          checkOutput("unexpected_we", 64'(we), 64'd0);
        end else begin
          wr_t e;
          e = expWrQ.pop_front();
          checkOutput("wa", 64'(wa), 64'(e.wa));
          checkOutput("wd", wd, e.wd);
          checkOutput("wbe", 64'(wbe), 64'(e.wbe));
        end
      end
    end
  end

  // Offer one pixel and hold it until accepted (bounded wait).
  task automatic applyStimulus(input logic [7:0] pix, input logic fs, input logic le);
    int budget;
    budget = 2000;
    @(negedge clk);
    in_valid       = 1'b1;
    in_pixel       = pix;
    in_frame_start = fs;
    in_line_end    = le;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      checkOutput("ready_timeout", 64'(in_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid       = 1'b0;
    in_frame_start = 1'b0;
    in_line_end    = 1'b0;
  endtask

  // Send one line; queue the expected word writes (pixels beyond LINE_W are
  // never written, a final partial word is flushed only on line end).
  task automatic sendLine(input int lineIdx, input int base, input int nPix,
                          input logic fs, input logic le, input int seed);
    logic [63:0] d;
    logic [7:0]  b;
    logic [7:0]  p;
    logic        last;
    wr_t         e;
    d = '0;
    b = '0;
    for (int i = 0; i < nPix; i++) begin
      p    = 8'(seed + lineIdx * 13 + i);
      last = (i == nPix - 1);
      if (i < LINE_W) begin
        d[(i % NP) * PS +: PS] = p;
        b[i % NP]              = 1'b1;
        if ((i % NP == NP - 1) || (last && le)) begin
          e.wa  = AW'(base + lineIdx * WPL + i / NP);
          e.wd  = d;
          e.wbe = b;
          expWrQ.push_back(e);
          d = '0;
          b = '0;
        end
      end
      applyStimulus(p, fs && (i == 0), le && last);
    end
  endtask

  task automatic sendStrip(input int base, input int seed, input logic fs, input logic bank);
    for (int l = 0; l < STRIP_H; l++) begin
      if (l == STRIP_H - 1) expStripQ.push_back(bank);
      sendLine(l, base, LINE_W, fs && (l == 0), 1'b1, seed);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_we"}, 64'(we), 64'd0);
    checkOutput({tag, "_wa"}, 64'(wa), 64'd0);
    checkOutput({tag, "_wd"}, wd, 64'd0);
    checkOutput({tag, "_wbe"}, 64'(wbe), 64'd0);
    checkOutput({tag, "_strip_valid"}, 64'(strip_valid), 64'd0);
    checkOutput({tag, "_strip_bank"}, 64'(strip_bank), 64'd0);
    checkOutput({tag, "_err_long"}, 64'(err_long_line), 64'd0);
    checkOutput({tag, "_err_partial"}, 64'(err_partial_strip), 64'd0);
  endtask

  task automatic pulseRelease(input string tag);
    strip_release = 1'b1;
    #1;
    checkOutput({tag, "_ready_before"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    strip_release = 1'b0;
    checkOutput({tag, "_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetn         = 1'b0;
    in_valid       = 1'b0;
    in_pixel       = '0;
    in_frame_start = 1'b0;
    in_line_end    = 1'b0;
    strip_release  = 1'b0;
    checkCount     = 0;
    passCount      = 0;
    cycle          = 0;
    lastWriteCycle = -100;

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    resetn = 1'b1;

    // Pixels before any frame start are discarded.
    for (int i = 0; i < 5; i++) applyStimulus(8'(i), 1'b0, 1'b0);

    // Full strip into bank 0.
    sendStrip(0, 1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("strip0_announced", 64'(expStripQ.size()), 64'd0);
    checkOutput("ready_after_strip0", 64'(in_ready), 64'd1);

    // Second strip into bank 1, then the writer must stall on bank 0.
    sendStrip(BANK_WORDS, 50, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("stall_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("stall_hold", 64'(in_ready), 64'd0);
    checkOutput("strip1_announced", 64'(expStripQ.size()), 64'd0);
    pulseRelease("release0");

    // Third strip resumes at bank 0: short line, full line, long line.
    sendLine(0, 0, 13, 1'b0, 1'b1, 100);
    sendLine(1, 0, LINE_W, 1'b0, 1'b1, 100);
    checkOutput("err_long_before", 64'(err_long_line), 64'd0);
    sendLine(2, 0, LINE_W + 10, 1'b0, 1'b1, 100);
    @(negedge clk);
    checkOutput("err_long_after", 64'(err_long_line), 64'(EXP_ERR));
    sendLine(3, 0, LINE_W, 1'b0, 1'b1, 100);
    sendLine(4, 0, LINE_W, 1'b0, 1'b1, 100);
    sendLine(5, 0, 20, 1'b0, 1'b0, 100);
    checkOutput("err_partial_before", 64'(err_partial_strip), 64'd0);

    // Frame start mid-strip: restart at line 0 of bank 0, no announcement.
    sendStrip(0, 200, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("err_partial_after", 64'(err_partial_strip), 64'(EXP_ERR));
    checkOutput("stall_ready2", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    pulseRelease("release1");

    // Partial strip into bank 1, then reset in the middle of line 7.
    for (int l = 0; l < 7; l++) sendLine(l, BANK_WORDS, 8, 1'b0, 1'b1, 300);
    sendLine(7, BANK_WORDS, 4, 1'b0, 1'b0, 300);
    repeat (4) @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    resetn = 1'b1;

    // After reset, pixels without frame start produce no writes.
    for (int i = 0; i < 10; i++) applyStimulus(8'(i + 9), 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("discard_ready", 64'(in_ready), 64'd1);

    // Single-pixel line: one write, wbe=8'h01, bank 0 address 0.
    sendLine(0, 0, 1, 1'b1, 1'b1, 77);
    repeat (6) @(negedge clk);

    checkOutput("writes_pending", 64'(expWrQ.size()), 64'd0);
    checkOutput("strips_pending", 64'(expStripQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
